// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding and buffered fetch entry.
package if_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: PC register control, instruction-memory port and decode-side handshake.
interface if_fetch_unit_if #(
  parameter int XLEN = if_pkg::XLEN_DEFAULT
);
  logic            pc_en_o;
  logic [XLEN-1:0] pc_i;
  logic            flush_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_instr_o;

  // master = fetch unit, slave = surrounding pipeline / memory
  modport master (
    input  pc_i, flush_i, imem_ack_i, imem_data_i, out_ready_i,
    output pc_en_o, imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o
  );

  modport slave (
    output pc_i, flush_i, imem_ack_i, imem_data_i, out_ready_i,
    input  pc_en_o, imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o
  );
endinterface

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched {pc, instr} pairs; clear empties it in one edge.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  T              din,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage is zeroed on reset so the head reads 0 until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, PC advance control, flush handling.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_fetch_unit_if.master   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   count;
  logic            req;
  logic            push;
  logic            pop;
  logic            valid;
  entry_t          din;
  entry_t          head;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)    pc_q <= '0;
    else if (req) pc_q <= bus.pc_i;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (bus.imem_ack_i) state_nxt = IDLE;
               else if (bus.flush_i) state_nxt = DROP;
      DROP:    if (bus.imem_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is gated on buffer room at issue time, so a push can never hit a full FIFO.
  always_comb begin
    req = 1'b0;
    if (!rst_i && state == IDLE && count < CW'(DEPTH) && !bus.flush_i) req = 1'b1;
    bus.imem_req_o  = req;
    bus.imem_addr_o = bus.pc_i;
    bus.pc_en_o     = !rst_i && (req || bus.flush_i);
  end

  // Reset gating keeps out_valid low in the very first reset cycle, before any edge.
  assign valid           = !rst_i && (count != '0);
  assign pop             = valid && bus.out_ready_i;
  assign push            = (state == BUSY) && bus.imem_ack_i && !bus.flush_i;
  assign din             = '{pc: pc_q, instr: bus.imem_data_i};
  assign bus.out_valid_o = valid;
  assign bus.out_pc_o    = head.pc;
  assign bus.out_instr_o = head.instr;

  if_fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (bus.flush_i),
    .din   (din),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random traffic vs a queue model.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.XLEN(32)) bus ();

  if_fetch_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // stimulus knobs
  logic        flush, ready, spur;
  logic [31:0] target, pc_reg;
  int          lat, cyc;
  // reference model: buffered entries plus one outstanding-request tracker
  ent_t        q[$];
  bit          pending, live;
  logic [31:0] pend_pc;
  mreq_t       mq[$];
  logic [31:0] req_log[$], pop_log[$];
  int          n_chk, n_fail;

  function automatic logic [31:0] imem_fn(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_5A13;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          mem_ack, ack, e_req, e_en, e_val, a_req, pop, push;
    logic [31:0] data, a_addr;
    @(negedge clk);
    mem_ack = (mq.size() > 0) && (mq[0].due == cyc);
    ack     = mem_ack || (spur && mq.size() == 0);
    data    = mem_ack ? imem_fn(mq[0].addr) : $urandom;
    bus.imem_ack_i  = ack;
    bus.imem_data_i = data;
    bus.flush_i     = flush;
    bus.out_ready_i = ready;
    bus.pc_i        = flush ? target : pc_reg;
    #1;
    e_req = !rst && !pending && (q.size() < DEPTH) && !flush;
    e_en  = !rst && (e_req || flush);
    e_val = !rst && (q.size() != 0);
    chk("imem_req", bus.imem_req_o, e_req);
    chk("pc_en", bus.pc_en_o, e_en);
    chk("out_valid", bus.out_valid_o, e_val);
    if (e_req) chk("imem_addr", bus.imem_addr_o, pc_reg);
    if (e_val) begin
      chk("out_pc", bus.out_pc_o, q[0].pc);
      chk("out_instr", bus.out_instr_o, q[0].instr);
    end
    a_req  = (bus.imem_req_o === 1'b1);
    a_addr = bus.imem_addr_o;
    if (a_req) req_log.push_back(a_addr);
    if (bus.out_valid_o === 1'b1 && ready) pop_log.push_back(bus.out_pc_o);
    @(posedge clk);
    if (mem_ack) void'(mq.pop_front());
    if (a_req) mq.push_back('{cyc + lat, a_addr});
    if (rst) begin
      q.delete();
      pending = 0;
    end else begin
      pop  = e_val && ready;
      push = pending && live && ack && !flush;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{pend_pc, data});
      end
      if (e_req) begin
        pending = 1; live = 1; pend_pc = pc_reg;
      end else if (pending && ack) pending = 0;
      else if (pending && flush) live = 0;
      if (e_en) pc_reg = flush ? target : pc_reg + 32'd4;
    end
    cyc++;
  endtask

  task automatic do_reset(int n);
    rst = 1; flush = 0; spur = 0;
    repeat (n) cycle();
    #2;
    chk("rst_out_pc", bus.out_pc_o, 32'h0);
    chk("rst_out_instr", bus.out_instr_o, 32'h0);
    chk("rst_count", 32'(dut.u_fifo.count), 32'h0);
    rst = 0;
    req_log.delete();
    pop_log.delete();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1; flush = 0; ready = 0; spur = 0; lat = 1;
    target = '0; pc_reg = '0; pending = 0; live = 0; pend_pc = '0;
    bus.pc_i = '0; bus.flush_i = 0; bus.imem_ack_i = 0; bus.imem_data_i = '0; bus.out_ready_i = 0;

    // 1: streaming fetch, L=1, ready high
    do_reset(2);
    pc_reg = 0; ready = 1; lat = 1;
    repeat (7) cycle();
    for (int i = 0; i < 3; i++) begin
      chk("t1_req_addr", i < req_log.size() ? req_log[i] : 32'hx, 32'(i * 4));
      chk("t1_pop_pc", i < pop_log.size() ? pop_log[i] : 32'hx, 32'(i * 4));
    end

    // 2: decode stalled, buffer fills to DEPTH then fetch stops
    do_reset(1);
    pc_reg = 0; ready = 0; lat = 1;
    repeat (10) cycle();
    chk("t2_nreq_full", req_log.size(), DEPTH);
    chk("t2_count_full", 32'(dut.u_fifo.count), DEPTH);
    ready = 1;
    cycle();
    chk("t2_pop_first", pop_log.size() > 0 ? pop_log[0] : 32'hx, 32'h0);
    cycle();
    chk("t2_next_req", req_log.size() == 3 ? req_log[2] : 32'hx, 32'h8);

    // 3: flush while BUSY, L=3
    do_reset(1);
    pc_reg = 0; ready = 1; lat = 3;
    cycle();
    flush = 1; target = 32'h100;
    cycle();
    flush = 0;
    #2;
    chk("t3_state_drop", 32'(dut.state), 32'(DROP));
    repeat (8) cycle();
    chk("t3_req_target", req_log.size() > 1 ? req_log[1] : 32'hx, 32'h100);
    chk("t3_first_pop", pop_log.size() > 0 ? pop_log[0] : 32'hx, 32'h100);

    // 4: flush coincides with ack and pop, one entry buffered
    do_reset(1);
    pc_reg = 0; ready = 0; lat = 1;
    repeat (3) cycle();
    ready = 1; flush = 1; target = 32'h200;
    cycle();
    flush = 0;
    #2;
    chk("t4_count_zero", 32'(dut.u_fifo.count), 32'h0);
    cycle();
    chk("t4_req_target", req_log.size() > 0 ? req_log[req_log.size()-1] : 32'hx, 32'h200);

    // 5: reset while BUSY, late ack lands in IDLE
    do_reset(1);
    pc_reg = 32'h40; ready = 1; lat = 3;
    cycle();
    rst = 1;
    repeat (2) cycle();
    #2;
    chk("t5_rst_out_pc", bus.out_pc_o, 32'h0);
    chk("t5_rst_count", 32'(dut.u_fifo.count), 32'h0);
    rst = 0;
    repeat (7) cycle();
    chk("t5_fresh_req", req_log.size() > 1 ? req_log[1] : 32'hx, 32'h44);
    chk("t5_first_pop", pop_log.size() > 0 ? pop_log[0] : 32'hx, 32'h44);

    // 6: push+pop with count=1, then pointer wrap over 10 fetches
    do_reset(1);
    pc_reg = 0; ready = 0; lat = 1;
    repeat (3) cycle();
    ready = 1;
    cycle();
    #2;
    chk("t6_count_hold", 32'(dut.u_fifo.count), 32'h1);
    chk("t6_new_head", bus.out_pc_o, 32'h4);
    repeat (30) cycle();
    for (int i = 0; i < 10; i++)
      chk("t6_wrap_pc", i < pop_log.size() ? pop_log[i] : 32'hx, 32'(i * 4));

    // 7: random traffic
    do_reset(1);
    pc_reg = 0;
    for (int i = 0; i < 800; i++) begin
      ready  = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 19) == 0);
      target = {$urandom_range(0, 32'hFFFF), 2'b00};
      lat    = $urandom_range(1, 4);
      spur   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 0; spur = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage sitting directly downstream of the PC register and upstream of the IF/ID boundary. Each cycle it decides whether the PC register may advance, issues single-cycle read requests to instruction memory at the current PC, and collects responses of variable latency. Fetched {pc, instr} pairs go into a small FIFO that decode drains with a valid/ready handshake. A taken-branch flush discards all in-flight and buffered work.

## Interface
Parameters:
- DEPTH, 2, fetch-buffer entries (power of two, ≥2)
- XLEN, 32, address/instruction width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- pc_i  in  XLEN  current value of the PC register
- pc_en_o  out  1  drives the PC register's load enable; 1 = PC loads its next value at this edge
- flush_i  in  1  redirect (taken branch/jump); upstream presents the target on the PC input in the same cycle
- imem_req_o  out  1  one-cycle read request pulse
- imem_addr_o  out  XLEN  request address, valid only while imem_req_o=1
- imem_ack_i  in  1  one-cycle response strobe, ≥1 cycle after the request
- imem_data_i  in  XLEN  instruction, valid with imem_ack_i
- out_valid_o  out  1  buffer head valid
- out_ready_i  in  1  decode accepts head
- out_pc_o  out  XLEN  PC of head entry
- out_instr_o  out  XLEN  instruction of head entry

## Operation
- FSM states: IDLE, BUSY (one request outstanding), DROP (outstanding request was flushed).
- IDLE: if count<DEPTH and !flush_i: imem_req_o=1, imem_addr_o=pc_i, pc_en_o=1, latch pc_q=pc_i, go to BUSY. Otherwise no request.
- BUSY: wait for imem_ack_i. Ack without flush: push {pc_q, imem_data_i}, go to IDLE. Ack with flush: discard, go to IDLE. Flush without ack: go to DROP.
- DROP: ack discards the data and moves to IDLE. flush_i is ignored apart from its effects on pc_en_o and the FIFO.
- Flush, any state: FIFO emptied (count=0, pointers 0) at the edge; pc_en_o=1 so the PC loads the target; no request issued that cycle.
- pc_en_o = (IDLE request issued) | flush_i. It is never 1 for any other reason.
- At most one outstanding request. An imem_ack_i in IDLE is a protocol violation and is ignored.
- FIFO: out_valid_o = (count≠0). Pop on out_valid_o & out_ready_i. Push and pop in the same cycle keeps count unchanged. Push never occurs when full, because requests are gated by count<DEPTH at issue. Flush overrides both push and pop.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.

## Timing
- During reset (rst_i=1 at an edge): state=IDLE, count=0, pointers=0, pc_q=0. In any cycle with rst_i=1, imem_req_o=0, pc_en_o=0 and out_valid_o=0. out_pc_o and out_instr_o read 0 after reset.
- Reset asserted mid-operation (BUSY/DROP) abandons the request. A late ack after reset lands in IDLE and is ignored.
- First request goes out in the first cycle with rst_i=0.
- With memory latency L (ack L cycles after req): the entry is visible on out_valid_o the cycle after the ack. Steady-state throughput is one instruction per L+1 cycles.
- imem_req_o, imem_addr_o and pc_en_o are combinational from state, count, flush_i and pc_i. Everything else is registered.
- Out outputs come from the FIFO head and are stable while out_valid_o=1 and out_ready_i=0, unless a flush occurs.

## Structure
- Package if_pkg: fetch_state_t enum {IDLE, BUSY, DROP}, XLEN_DEFAULT=32, entry struct {pc, instr}.
- Sub-module if_fetch_fifo: synchronous DEPTH-entry FIFO with push, pop, clear, count, head output, and synchronous active-high reset.
- The top holds the FSM, pc_q, and the request/enable logic.

## Test plan
- Reset then pc_i=0x0, L=1, out_ready_i=1: requests at 0x0, 0x4, 0x8 every 2 cycles. Outputs are {0x0,I0},{0x4,I1},{0x8,I2} in order. pc_en_o pulses with each request.
- out_ready_i=0, L=1: exactly DEPTH=2 requests issue, then imem_req_o stays 0 and pc_en_o stays 0. Raising out_ready_i pops 0x0 and the next request follows in the next cycle.
- Flush in BUSY (L=3) with target 0x100: state goes to DROP, the late data for the old PC is discarded, the FIFO empties, pc_en_o=1 in the flush cycle, and the next request is at 0x100.
- Flush coinciding with ack and pop while the FIFO holds one entry: nothing is pushed, count=0, out_valid_o=0 next cycle, and the next request uses the target.
- Assert rst_i while BUSY, then an ack arrives after reset: no push, outputs at reset values, and a fresh request at the current pc_i.
- Push and pop in the same cycle with count=1: count stays 1, the new entry becomes head next cycle, and the pointers wrap correctly over 10 consecutive fetches.
